// File: rtl/conv1_pkg.sv
// Shared constants, FSM encoding and helpers for the conv1 PE column controller.
package conv1_pkg;

  localparam int DATA_W = 8;
  localparam int FILT_W = 24;
  localparam int PSUM_W = 20;
  localparam int KERNEL = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_FILT = 3'd1,
    STREAM    = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  function automatic int n_out(input int w, input int k);
    return w - k + 1;
  endfunction

endpackage

// File: rtl/conv1_psum_out_reg.sv
// Output pixel register: holds data/last stable while valid && !ready.
// Optional clamp of negative psums to zero when CONV1_CTRL_RELU_EN is defined.
module conv1_psum_out_reg
  import conv1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              last_in,
  input  logic              psum_ready,
  output logic              psum_valid,
  output logic [PSUM_W-1:0] psum_data,
  output logic              psum_last
);

  logic [PSUM_W-1:0] psum_clamped;

  always_comb begin
`ifdef CONV1_CTRL_RELU_EN
    psum_clamped = psum_in[PSUM_W-1] ? '0 : psum_in;
`else
    psum_clamped = psum_in;
`endif
  end

  // capture is only raised when the slot is free, so a held pixel is never overwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      psum_valid <= 1'b0;
      psum_data  <= '0;
      psum_last  <= 1'b0;
    end else if (capture) begin
      psum_valid <= 1'b1;
      psum_data  <= psum_clamped;
      psum_last  <= last_in;
    end else if (psum_ready) begin
      psum_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv1_pe_col_ctrl.sv
// Sequencer for one conv1 PE column: filter load, ifmap streaming, drain bubbles
// and psum hand-off. Optional ReLU clamp via CONV1_CTRL_RELU_EN (in conv1_psum_out_reg).
module conv1_pe_col_ctrl
  import conv1_pkg::*;
#(
  parameter int IFMAP_W  = 28,
  parameter int PSUM_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              filt_valid,
  output logic              filt_ready,
  input  logic [FILT_W-1:0] filt_data,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_data_0,
  input  logic [DATA_W-1:0] if_data_1,
  input  logic [DATA_W-1:0] if_data_2,
  output logic              pe_en,
  output logic [DATA_W-1:0] pe_ifmap_0,
  output logic [DATA_W-1:0] pe_ifmap_1,
  output logic [DATA_W-1:0] pe_ifmap_2,
  output logic [FILT_W-1:0] pe_filtr_0,
  output logic [FILT_W-1:0] pe_filtr_1,
  output logic [FILT_W-1:0] pe_filtr_2,
  input  logic [PSUM_W-1:0] pe_psum,
  output logic              psum_valid,
  input  logic              psum_ready,
  output logic [PSUM_W-1:0] psum_data,
  output logic              psum_last,
  output state_t            dbg_state
);

  localparam int N_OUT = n_out(IFMAP_W, KERNEL);
  localparam int CW    = $clog2(IFMAP_W + 1);
  localparam int BW    = $clog2(PSUM_LAT + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(IFMAP_W - 1);
  localparam logic [CW-1:0] FIRST_TAG = CW'(KERNEL - 1);
  localparam logic [CW-1:0] LAST_OUT  = CW'(N_OUT - 1);
  localparam logic [BW-1:0] N_BUB     = BW'(PSUM_LAT - 1);

  state_t state, state_nx;
  logic [1:0]          fcnt;
  logic [CW-1:0]       beat_cnt, out_cnt;
  logic [PSUM_LAT-1:0] tag_q;
  logic [BW-1:0]       bub_cnt;
  logic                taken, last_hs;
  logic                slot_free, tag_hold, adv, capture, bub_done, filt_hs, last_now;

  // All three ports transfer a word on a cycle where valid && ready; valid never
  // waits on ready, and psum_valid holds data/last stable until psum_ready.
  assign slot_free = !psum_valid || psum_ready;
  assign tag_hold  = tag_q[PSUM_LAT-1] && !taken;
  assign adv       = !tag_hold || slot_free;
  assign capture   = tag_hold && slot_free;
  assign bub_done  = (bub_cnt == N_BUB);
  assign filt_hs   = filt_valid && filt_ready;
  assign last_now  = psum_valid && psum_ready && psum_last;
  assign dbg_state = state;

  always_comb begin
    state_nx   = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    filt_ready = 1'b0;
    if_ready   = 1'b0;
    pe_en      = 1'b0;
    case (state)
      IDLE:      if (start) state_nx = LOAD_FILT;
      LOAD_FILT: begin
        filt_ready = 1'b1;
        if (filt_valid && fcnt == 2'd2) state_nx = STREAM;
      end
      STREAM: begin
        if_ready = adv;
        pe_en    = adv && if_valid;
        if (pe_en && beat_cnt == LAST_BEAT) state_nx = DRAIN;
      end
      DRAIN: begin
        pe_en = adv && !bub_done;
        if (bub_done && tag_q == '0 && (last_hs || last_now)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fcnt       <= '0;
      pe_filtr_0 <= '0;
      pe_filtr_1 <= '0;
      pe_filtr_2 <= '0;
      beat_cnt   <= '0;
      out_cnt    <= '0;
      tag_q      <= '0;
      bub_cnt    <= '0;
      taken      <= 1'b0;
      last_hs    <= 1'b0;
      pe_ifmap_0 <= '0;
      pe_ifmap_1 <= '0;
      pe_ifmap_2 <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        fcnt    <= '0;
        tag_q   <= '0;
        bub_cnt <= '0;
        taken   <= 1'b0;
        last_hs <= 1'b0;
      end
      if (filt_hs) begin
        case (fcnt)
          2'd0:    pe_filtr_0 <= filt_data;
          2'd1:    pe_filtr_1 <= filt_data;
          default: pe_filtr_2 <= filt_data;
        endcase
        fcnt <= fcnt + 2'd1;
        if (fcnt == 2'd2) begin
          beat_cnt <= '0;
          out_cnt  <= '0;
        end
      end
      if (pe_en) begin
        tag_q <= {tag_q[PSUM_LAT-2:0], (state == STREAM) && (beat_cnt >= FIRST_TAG)};
        taken <= 1'b0;
        if (state == STREAM) begin
          pe_ifmap_0 <= if_data_0;
          pe_ifmap_1 <= if_data_1;
          pe_ifmap_2 <= if_data_2;
          beat_cnt   <= beat_cnt + CW'(1);
        end else begin
          pe_ifmap_0 <= '0;
          pe_ifmap_1 <= '0;
          pe_ifmap_2 <= '0;
          bub_cnt    <= bub_cnt + BW'(1);
        end
      end else if (capture) begin
        // once bubbles are spent the column no longer steps, so retire the tag directly
        if (state == DRAIN && bub_done) tag_q[PSUM_LAT-1] <= 1'b0;
        else                            taken <= 1'b1;
      end
      if (capture)  out_cnt <= out_cnt + CW'(1);
      if (last_now) last_hs <= 1'b1;
    end
  end

  conv1_psum_out_reg u_out (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .psum_in    (pe_psum),
    .last_in    (out_cnt == LAST_OUT),
    .psum_ready (psum_ready),
    .psum_valid (psum_valid),
    .psum_data  (psum_data),
    .psum_last  (psum_last)
  );

endmodule

// File: tb/tb_conv1_pe_col_ctrl.sv
// Bench for conv1_pe_col_ctrl: behavioural PE column, convolution reference and scoreboard.
// Expectations follow CONV1_CTRL_RELU_EN the same way as the design build.
module tb_conv1_pe_col_ctrl;
  import conv1_pkg::*;

  localparam int IFMAP_W  = 28;
  localparam int PSUM_LAT = 3;
  localparam int N_OUT    = IFMAP_W - KERNEL + 1;

  logic              clk, rst, start, busy, done;
  logic              filt_valid, filt_ready;
  logic [FILT_W-1:0] filt_data;
  logic              if_valid, if_ready;
  logic [DATA_W-1:0] if_data_0, if_data_1, if_data_2;
  logic              pe_en;
  logic [DATA_W-1:0] pe_ifmap_0, pe_ifmap_1, pe_ifmap_2;
  logic [FILT_W-1:0] pe_filtr_0, pe_filtr_1, pe_filtr_2;
  logic [PSUM_W-1:0] pe_psum;
  logic              psum_valid, psum_ready, psum_last;
  logic [PSUM_W-1:0] psum_data;
  state_t            dbg_state;

  conv1_pe_col_ctrl #(.IFMAP_W(IFMAP_W), .PSUM_LAT(PSUM_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_data(filt_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_data_0(if_data_0), .if_data_1(if_data_1), .if_data_2(if_data_2),
    .pe_en(pe_en), .pe_ifmap_0(pe_ifmap_0), .pe_ifmap_1(pe_ifmap_1), .pe_ifmap_2(pe_ifmap_2),
    .pe_filtr_0(pe_filtr_0), .pe_filtr_1(pe_filtr_1), .pe_filtr_2(pe_filtr_2),
    .pe_psum(pe_psum), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .psum_last(psum_last), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [PSUM_W-1:0] exp_q[$];
  int img [3][IFMAP_W];
  int w   [3][3];
  logic [FILT_W-1:0] fw [3];
  int  acc2_cyc;
  int  n_seen;
  bit  pass_end;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural PE column ----------------
  int hist [3][64];
  int steps;
  int col_k;

  function automatic int wt(input logic [FILT_W-1:0] f, input int c);
    logic [7:0] b;
    b = f[c*8 +: 8];
    return int'($signed(b));
  endfunction

  function automatic logic [FILT_W-1:0] pf(input int r);
    case (r)
      0:       return pe_filtr_0;
      1:       return pe_filtr_1;
      default: return pe_filtr_2;
    endcase
  endfunction

  function automatic int col_dot(input int j);
    int s;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < KERNEL; c++)
        s += wt(pf(r), c) * hist[r][j+c];
    return s;
  endfunction

  // Psum_out for beat k appears once the column has stepped PSUM_LAT-1 further beats
  always @(posedge clk) begin
    if (rst || !busy) begin
      steps = 0;
    end else if (pe_en) begin
      if (steps < 64) begin
        hist[0][steps] = if_ready ? int'(if_data_0) : 0;
        hist[1][steps] = if_ready ? int'(if_data_1) : 0;
        hist[2][steps] = if_ready ? int'(if_data_2) : 0;
      end
      steps++;
      col_k = steps - PSUM_LAT;
      if (col_k >= KERNEL-1 && col_k < IFMAP_W) pe_psum <= PSUM_W'(col_dot(col_k - (KERNEL-1)));
      else                                      pe_psum <= PSUM_W'($urandom);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [PSUM_W-1:0] ref_out(input int j);
    int s;
    logic [PSUM_W-1:0] e;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < KERNEL; c++)
        s += w[r][c] * img[r][j+c];
    e = PSUM_W'(s);
`ifdef CONV1_CTRL_RELU_EN
    if (e[PSUM_W-1]) e = '0;
`endif
    return e;
  endfunction

  // pattern 0: random; 1: all-ones image, unit weights; 2: all-ones image, single weight -5
  task automatic gen_pass(input int pattern);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        case (pattern)
          0:       w[r][c] = int'($urandom_range(255)) - 128;
          1:       w[r][c] = 1;
          default: w[r][c] = (r == 0 && c == 0) ? -5 : 0;
        endcase
        fw[r][c*8 +: 8] = 8'(w[r][c]);
      end
      for (int x = 0; x < IFMAP_W; x++)
        img[r][x] = (pattern == 0) ? int'($urandom_range(255)) : 1;
    end
    exp_q.delete();
    for (int j = 0; j < N_OUT; j++) exp_q.push_back(ref_out(j));
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_ctl", {busy, done, filt_ready, if_ready, pe_en, psum_valid, psum_last}, 0);
    check("rst_ifmap", {pe_ifmap_2, pe_ifmap_1, pe_ifmap_0}, 0);
    check("rst_filt0", pe_filtr_0, 0);
    check("rst_filt1", pe_filtr_1, 0);
    check("rst_filt2", pe_filtr_2, 0);
    check("rst_psum", psum_data, 0);
    check("rst_state", dbg_state, IDLE);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    #1 check("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_busy", busy, 1);
    check("state_load", dbg_state, LOAD_FILT);
  endtask

  task automatic load_filters(input int gap);
    for (int r = 0; r < 3; r++) begin
      int t;
      t = 0;
      @(negedge clk);
      filt_valid = 1'b1;
      filt_data  = fw[r];
      #1;
      while (!filt_ready && t < 50) begin
        @(negedge clk);
        #1;
        t++;
      end
      check("filt_ready", filt_ready, 1);
      if (r < 2) repeat (gap) begin
        @(negedge clk);
        filt_valid = 1'b0;
      end
    end
    @(negedge clk);
    filt_valid = 1'b0;
    filt_data  = FILT_W'($urandom);
    #1;
    check("state_stream", dbg_state, STREAM);
    check("filtr0", pe_filtr_0, fw[0]);
    check("filtr1", pe_filtr_1, fw[1]);
    check("filtr2", pe_filtr_2, fw[2]);
  endtask

  task automatic drive_ifmap(input int vpct, input bit poke_start);
    int idx, t;
    logic pend;
    logic [3*DATA_W-1:0] pd;
    idx = 0; t = 0; pend = 1'b0; pd = '0;
    while (idx < IFMAP_W && t < 3000) begin
      @(negedge clk);
      t++;
      if (pend) check("pe_ifmap", {pe_ifmap_2, pe_ifmap_1, pe_ifmap_0}, pd);
      pend = 1'b0;
      if_valid  = ($urandom_range(99) < vpct);
      if_data_0 = DATA_W'(img[0][idx]);
      if_data_1 = DATA_W'(img[1][idx]);
      if_data_2 = DATA_W'(img[2][idx]);
      start     = poke_start && ($urandom_range(3) == 0);
      #1;
      if (if_valid && if_ready) begin
        if (idx == KERNEL-1) acc2_cyc = cyc + 1;
        pend = 1'b1;
        pd   = {if_data_2, if_data_1, if_data_0};
        idx++;
      end
    end
    check("beats_in", idx, IFMAP_W);
    @(negedge clk);
    if (pend) check("pe_ifmap", {pe_ifmap_2, pe_ifmap_1, pe_ifmap_0}, pd);
    if_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic drive_sink(input int rpct, input bit stall);
    bit stalled;
    stalled = 1'b0;
    while (!pass_end) begin
      @(negedge clk);
      if (stall && !stalled && n_seen == 4 && psum_valid) begin
        stalled = 1'b1;
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          psum_ready = 1'b0;
          #1;
          if (s >= 2) begin
            check("stall_pe_en", pe_en, 0);
            check("stall_if_ready", if_ready, 0);
          end
        end
      end else begin
        psum_ready = ($urandom_range(99) < rpct);
      end
    end
  endtask

  task automatic monitor(input bit timing_chk);
    int n, dn, t, first, last_cyc, done_cyc;
    logic hold, hl;
    logic [PSUM_W-1:0] hd, e;
    n = 0; dn = 0; t = 0; first = -1; last_cyc = -1; done_cyc = -2;
    hold = 1'b0; hl = 1'b0; hd = '0;
    while (dn == 0 && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
      if (hold) begin
        check("hold_valid", psum_valid, 1);
        check("hold_data", psum_data, hd);
        check("hold_last", psum_last, hl);
      end
      if (psum_valid && first < 0) first = cyc;
      if (psum_valid && psum_ready) begin
        check("out_in_range", n < N_OUT, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("psum_data", psum_data, e);
        end
        check("psum_last", psum_last, n == N_OUT-1);
        if (psum_last) last_cyc = cyc + 1;
        n++;
        n_seen = n;
      end
      hold = psum_valid && !psum_ready;
      hd   = psum_data;
      hl   = psum_last;
      if (done) begin
        dn++;
        done_cyc = cyc;
      end
    end
    pass_end = 1'b1;
    check("done_seen", dn, 1);
    check("out_count", n, N_OUT);
    check("exp_q_empty", exp_q.size(), 0);
    @(negedge clk);
    #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    if (timing_chk) begin
      check("first_latency", first - acc2_cyc, PSUM_LAT);
      check("done_timing", done_cyc, last_cyc);
    end
  endtask

  task automatic run_pass(input int pattern, input int fgap, input int vpct, input int rpct,
                          input bit stall, input bit timing_chk, input bit poke);
    gen_pass(pattern);
    do_start();
    load_filters(fgap);
    pass_end = 1'b0;
    n_seen   = 0;
    acc2_cyc = -100;
    fork
      drive_ifmap(vpct, poke);
      drive_sink(rpct, stall);
      monitor(timing_chk);
    join
  endtask

  task automatic reset_mid_stream();
    int idx, t;
    gen_pass(0);
    do_start();
    load_filters(0);
    idx = 0; t = 0;
    psum_ready = 1'b1;
    while (idx < 10 && t < 200) begin
      @(negedge clk);
      t++;
      if_valid  = 1'b1;
      if_data_0 = DATA_W'(img[0][idx]);
      if_data_1 = DATA_W'(img[1][idx]);
      if_data_2 = DATA_W'(img[2][idx]);
      #1;
      if (if_ready) idx++;
    end
    check("abort_beats", idx, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs();
    rst      = 1'b0;
    if_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("abort_no_done", {done, busy, psum_valid}, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; filt_valid = 1'b0; filt_data = '0;
    if_valid = 1'b0; if_data_0 = '0; if_data_1 = '0; if_data_2 = '0;
    psum_ready = 1'b1; pe_psum = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    rst = 1'b0;

    reset_mid_stream();
    run_pass(1, 0, 100, 100, 1'b0, 1'b1, 1'b0);
    run_pass(0, 2, 100, 100, 1'b1, 1'b0, 1'b0);
    run_pass(0, 0,  50, 100, 1'b0, 1'b0, 1'b1);
    run_pass(0, 1,  70,  60, 1'b0, 1'b0, 1'b1);
    run_pass(2, 0, 100, 100, 1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++)
      run_pass(0, $urandom_range(2), $urandom_range(40, 100), $urandom_range(40, 100),
               1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
